// File: rtl/hazard_scheduler.sv
//==============================================================================
// Module      : hazard_scheduler
// Description : Pipeline sequencing controller for the 5-stage core.
//               - Detects load-use hazards of the ID instruction against the
//                 load in EX and inserts a single bubble.
//               - Resolves taken branches from EX by flushing IF/ID and ID/EX.
//               - Freezes the pipeline while a multi-cycle EX op (mul/div)
//                 occupies EX for MC_LATENCY cycles, then pulses mc_done.
// Ports       : clk, reset (async, active-high)
//               id_valid, id_rs1_addr, id_rs2_addr           - ID stage info
//               ex_mem_read, ex_reg_write, ex_rd_addr,
//               ex_multicycle, ex_branch_taken               - EX stage info
//               stall, pc_write, if_id_write, id_ex_hold,
//               flush                                        - pipeline control
//               mc_busy, mc_done                             - multi-cycle status
//               perf_stall_cycles                            - stall counter
// Options     : define HAZARD_PERF_EN to build the saturating stall counter;
//               otherwise perf_stall_cycles is tied to zero.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_scheduler #(
    parameter int MC_LATENCY = 4   // total EX occupancy of a multi-cycle op, 2..65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_multicycle,
    input  logic        ex_branch_taken,
    output logic        stall,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_hold,
    output logic        flush,
    output logic        mc_busy,
    output logic        mc_done,
    output logic [31:0] perf_stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MC_WAIT = 2'd1,
        S_MC_LAST = 2'd2
    } state_t;

    // Counter preload on entry to MC_WAIT: RUN and MC_LAST each take one
    // cycle, so MC_WAIT lasts MC_LATENCY-2 cycles (count down to zero).
    localparam logic [15:0] MC_CNT_INIT = (MC_LATENCY >= 3) ? 16'(MC_LATENCY - 3) : 16'd0;

    state_t      state_q, state_d;
    logic [15:0] mc_cnt_q, mc_cnt_d;

    logic        load_use;
    logic        stall_d, pc_write_d, if_id_write_d, id_ex_hold_d, flush_d;
    logic        mc_busy_d, mc_done_d;

    assign load_use = id_valid & ex_mem_read & ex_reg_write & (ex_rd_addr != 5'd0) &
                      ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr));

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_RUN;
            mc_cnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and control decode
    //--------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        mc_cnt_d      = mc_cnt_q;
        stall_d       = 1'b0;
        pc_write_d    = 1'b1;
        if_id_write_d = 1'b1;
        id_ex_hold_d  = 1'b0;
        flush_d       = 1'b0;
        mc_busy_d     = 1'b0;
        mc_done_d     = 1'b0;

        unique case (state_q)
            S_RUN: begin
                // Multi-cycle wins even over a (illegal) simultaneous branch;
                // that branch is picked up again in MC_LAST.
                if (ex_multicycle) begin
                    pc_write_d    = 1'b0;
                    if_id_write_d = 1'b0;
                    id_ex_hold_d  = 1'b1;
                    if (MC_LATENCY == 2) begin
                        state_d = S_MC_LAST;
                    end else begin
                        state_d  = S_MC_WAIT;
                        mc_cnt_d = MC_CNT_INIT;
                    end
                end else if (ex_branch_taken) begin
                    flush_d = 1'b1;
                end else if (load_use) begin
                    stall_d       = 1'b1;
                    pc_write_d    = 1'b0;
                    if_id_write_d = 1'b0;
                end
            end

            S_MC_WAIT: begin
                pc_write_d    = 1'b0;
                if_id_write_d = 1'b0;
                id_ex_hold_d  = 1'b1;
                mc_busy_d     = 1'b1;
                if (!ex_multicycle) begin
                    // Op vanished from EX: abort without a done pulse.
                    state_d = S_RUN;
                end else if (mc_cnt_q == 16'd0) begin
                    state_d = S_MC_LAST;
                end else begin
                    mc_cnt_d = mc_cnt_q - 16'd1;
                end
            end

            S_MC_LAST: begin
                mc_busy_d = 1'b1;
                mc_done_d = 1'b1;
                // ex_multicycle is still high here for the finishing op, so it
                // must not restart the sequence.
                if (ex_branch_taken) begin
                    flush_d = 1'b1;
                end
                state_d = S_RUN;
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Outputs: reset forces a safe flush pattern without waiting for a clock
    //--------------------------------------------------------------------------
    always_comb begin
        stall       = stall_d;
        pc_write    = pc_write_d;
        if_id_write = if_id_write_d;
        id_ex_hold  = id_ex_hold_d;
        flush       = flush_d;
        mc_busy     = mc_busy_d;
        mc_done     = mc_done_d;
        if (reset) begin
            stall       = 1'b0;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_hold  = 1'b0;
            flush       = 1'b1;
            mc_busy     = 1'b0;
            mc_done     = 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    //--------------------------------------------------------------------------
    // Saturating count of cycles in which the PC did not advance
    //--------------------------------------------------------------------------
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= 32'd0;
        end else if (!pc_write_d && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_q;
`else
    assign perf_stall_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
//==============================================================================
// Module      : tb_hazard_scheduler
// Description : Self-checking bench for hazard_scheduler (MC_LATENCY = 4).
//               Table of single-cycle RUN-state vectors plus hand-written
//               multi-cycle, abort, branch-in-MC_LAST and reset sequences.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hazard_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        ex_mem_read;
    logic        ex_reg_write;
    logic [4:0]  ex_rd_addr;
    logic        ex_multicycle;
    logic        ex_branch_taken;
    logic        stall;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_hold;
    logic        flush;
    logic        mc_busy;
    logic        mc_done;
    logic [31:0] perf_stall_cycles;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_scheduler #(.MC_LATENCY(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .id_valid          (id_valid),
        .id_rs1_addr       (id_rs1_addr),
        .id_rs2_addr       (id_rs2_addr),
        .ex_mem_read       (ex_mem_read),
        .ex_reg_write      (ex_reg_write),
        .ex_rd_addr        (ex_rd_addr),
        .ex_multicycle     (ex_multicycle),
        .ex_branch_taken   (ex_branch_taken),
        .stall             (stall),
        .pc_write          (pc_write),
        .if_id_write       (if_id_write),
        .id_ex_hold        (id_ex_hold),
        .flush             (flush),
        .mc_busy           (mc_busy),
        .mc_done           (mc_done),
        .perf_stall_cycles (perf_stall_cycles)
    );

    // Output bit order: {stall, pc_write, if_id_write, id_ex_hold, flush, mc_busy, mc_done}
    localparam logic [6:0] O_IDLE   = 7'b0110000;
    localparam logic [6:0] O_RESET  = 7'b0000100;
    localparam logic [6:0] O_BUBBLE = 7'b1000000;
    localparam logic [6:0] O_FLUSH  = 7'b0110100;
    localparam logic [6:0] O_FRZ0   = 7'b0001000;  // freeze, first cycle (still RUN)
    localparam logic [6:0] O_FRZ    = 7'b0001010;  // freeze in MC_WAIT
    localparam logic [6:0] O_DONE   = 7'b0110011;
    localparam logic [6:0] O_DONEBR = 7'b0110111;

    typedef struct {
        string      name;
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       mr;
        logic       rw;
        logic [4:0] rd;
        logic       br;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic mr, input logic rw, input logic [4:0] rd,
                         input logic mc, input logic br);
        id_valid        = v;
        id_rs1_addr     = rs1;
        id_rs2_addr     = rs2;
        ex_mem_read     = mr;
        ex_reg_write    = rw;
        ex_rd_addr      = rd;
        ex_multicycle   = mc;
        ex_branch_taken = br;
    endtask

    task automatic drive_idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {stall, pc_write, if_id_write, id_ex_hold, flush, mc_busy, mc_done};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {stall,pc,ifid,hold,flush,busy,done}=%b expected %b",
                     name, act, exp);
        end
    endtask

    task automatic chk_perf(input string name, input logic [31:0] exp);
        checks++;
        if (perf_stall_cycles !== exp) begin
            failures++;
            $display("FAIL %s: perf_stall_cycles got %0d expected %0d",
                     name, perf_stall_cycles, exp);
        end
    endtask

    // Drive just after a rising edge, sample on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_perf;
`ifdef HAZARD_PERF_EN
        exp_perf = 32'd4;
`else
        exp_perf = 32'd0;
`endif
        //                 name          v     rs1    rs2    mr    rw    rd     br    exp
        vecs[0] = '{"idle",         1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, O_IDLE};
        vecs[1] = '{"lu_rs1",       1'b1, 5'd5,  5'd0,  1'b1, 1'b1, 5'd5,  1'b0, O_BUBBLE};
        vecs[2] = '{"lu_rs2",       1'b1, 5'd3,  5'd7,  1'b1, 1'b1, 5'd7,  1'b0, O_BUBBLE};
        vecs[3] = '{"x0_excluded",  1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0, O_IDLE};
        vecs[4] = '{"not_load",     1'b1, 5'd5,  5'd0,  1'b0, 1'b1, 5'd5,  1'b0, O_IDLE};
        vecs[5] = '{"no_regwrite",  1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b0, O_IDLE};
        vecs[6] = '{"id_invalid",   1'b0, 5'd5,  5'd5,  1'b1, 1'b1, 5'd5,  1'b0, O_IDLE};
        vecs[7] = '{"no_match",     1'b1, 5'd6,  5'd4,  1'b1, 1'b1, 5'd5,  1'b0, O_IDLE};
        vecs[8] = '{"br_beats_lu",  1'b1, 5'd5,  5'd0,  1'b1, 1'b1, 5'd5,  1'b1, O_FLUSH};
        vecs[9] = '{"branch_only",  1'b1, 5'd1,  5'd2,  1'b0, 1'b0, 5'd9,  1'b1, O_FLUSH};

        // ---------------- reset state ----------------
        reset = 1'b1;
        drive_idle();
        #12;
        chk("reset_outputs", O_RESET);
        chk_perf("reset_perf", 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- load-use bubble then clear ----------------
        next_cycle();
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        @(negedge clk); chk("lu_bubble", O_BUBBLE);
        next_cycle();
        drive(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        @(negedge clk); chk("lu_after", O_IDLE);

        // ---------------- multi-cycle op, held high through MC_LAST ----------------
        next_cycle(); drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        @(negedge clk); chk("mc_t0", O_FRZ0);
        next_cycle();
        @(negedge clk); chk("mc_t1", O_FRZ);
        next_cycle();
        @(negedge clk); chk("mc_t2", O_FRZ);
        next_cycle();
        @(negedge clk); chk("mc_t3_done", O_DONE);
        next_cycle(); drive_idle();
        @(negedge clk); chk("mc_no_retrigger", O_IDLE);
        chk_perf("perf_lu_plus_mc", exp_perf);

        // ---------------- RUN-state vector table ----------------
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].mr, vecs[i].rw,
                  vecs[i].rd, 1'b0, vecs[i].br);
            @(negedge clk);
            chk(vecs[i].name, vecs[i].exp);
        end

        // ---------------- branch honoured in MC_LAST ----------------
        next_cycle(); drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        @(negedge clk); chk("mcbr_t0", O_FRZ0);
        next_cycle(); ex_branch_taken = 1'b1;   // ignored while waiting
        @(negedge clk); chk("mcbr_t1_br_ignored", O_FRZ);
        next_cycle(); ex_branch_taken = 1'b0;
        @(negedge clk); chk("mcbr_t2", O_FRZ);
        next_cycle(); ex_branch_taken = 1'b1;
        @(negedge clk); chk("mcbr_t3_flush", O_DONEBR);
        next_cycle(); drive_idle();
        @(negedge clk); chk("mcbr_t4", O_IDLE);

        // ---------------- abort: ex_multicycle drops in MC_WAIT ----------------
        next_cycle(); drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        @(negedge clk); chk("abort_t0", O_FRZ0);
        next_cycle();
        @(negedge clk); chk("abort_t1", O_FRZ);
        next_cycle(); drive_idle();
        @(negedge clk); chk("abort_t2_wait", O_FRZ);
        next_cycle();
        @(negedge clk); chk("abort_t3_run", O_IDLE);

        // ---------------- reset pulse during MC_WAIT ----------------
        next_cycle(); drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        @(negedge clk); chk("rst_mc_t0", O_FRZ0);
        next_cycle();
        @(negedge clk); chk("rst_mc_t1", O_FRZ);
        #1;
        reset = 1'b1;
        drive_idle();
        #1;
        chk("rst_async_outputs", O_RESET);
        chk_perf("rst_async_perf", 32'd0);
        @(negedge clk);
        reset = 1'b0;
        next_cycle();
        @(negedge clk); chk("rst_release_run", O_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
